// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - I2C byte-stream program loader and memory-port controller for the synth core
module boot_loader #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              reload,
    input  logic [ADDR_W-1:0] core_mem_address,
    input  logic [DATA_W-1:0] core_mem_data,
    input  logic              core_mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int          CNT_W     = ADDR_W + 1;
    localparam logic [15:0] MAX_WORDS = 16'(1 << ADDR_W);

    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA_HI, DATA_LO, RUN, ERR} state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        hdr_hi;
    logic [7:0]        data_hi;
    logic [CNT_W-1:0]  n_words;
    logic [CNT_W-1:0]  wc;
    logic [TMO_W-1:0]  tmo;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    logic [15:0] hdr_n;
    logic        loading;
    logic        tmo_hit;
    logic        last_word;
    logic        loader_owns;

    assign hdr_n     = {hdr_hi, byte_data};
    assign loading   = (state == HDR_LO) || (state == DATA_HI) || (state == DATA_LO);
    assign tmo_hit   = loading && !byte_valid && (tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign last_word = (wc + CNT_W'(1)) == n_words;
    // The final word's write lands in the first RUN cycle, so the loader keeps the port then.
    assign loader_owns  = (state != RUN) || ld_we;
    assign words_loaded = wc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR_HI;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, status flags and the memory-port mux
    always_comb begin
        state_next  = state;
        busy        = loading;
        done        = (state == RUN);
        err         = (state == ERR);
        core_rst    = loader_owns;
        mem_address = core_mem_address;
        mem_data    = core_mem_data;
        mem_we      = core_mem_we;
        if (loader_owns) begin
            mem_address = ld_addr;
            mem_data    = ld_data;
            mem_we      = ld_we;
        end
        if (reload) begin
            state_next = HDR_HI;
        end else begin
            case (state)
                HDR_HI: begin
                    if (byte_valid) state_next = HDR_LO;
                end
                HDR_LO: begin
                    if (byte_valid) begin
                        if (hdr_n > MAX_WORDS)  state_next = ERR;
                        else if (hdr_n == 16'd0) state_next = RUN;
                        else                     state_next = DATA_HI;
                    end else if (tmo_hit) begin
                        state_next = ERR;
                    end
                end
                DATA_HI: begin
                    if (byte_valid)   state_next = DATA_LO;
                    else if (tmo_hit) state_next = ERR;
                end
                DATA_LO: begin
                    if (byte_valid)   state_next = last_word ? RUN : DATA_HI;
                    else if (tmo_hit) state_next = ERR;
                end
                default: state_next = state;
            endcase
        end
    end

    // Byte assembly, word counter, idle timer and the registered loader write
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            hdr_hi  <= '0;
            data_hi <= '0;
            n_words <= '0;
            wc      <= '0;
            tmo     <= '0;
            ld_we   <= 1'b0;
            ld_addr <= '0;
            ld_data <= '0;
        end else begin
            ld_we <= 1'b0;
            if (!loading || byte_valid || (state_next != state)) begin
                tmo <= '0;
            end else begin
                tmo <= tmo + TMO_W'(1);
            end
            case (state)
                HDR_HI:  if (byte_valid) hdr_hi <= byte_data;
                HDR_LO:  if (byte_valid) n_words <= hdr_n[CNT_W-1:0];
                DATA_HI: if (byte_valid) data_hi <= byte_data;
                DATA_LO: begin
                    if (byte_valid) begin
                        ld_we   <= 1'b1;
                        ld_data <= DATA_W'({data_hi, byte_data});
                        ld_addr <= wc[ADDR_W-1:0];
                        wc      <= wc + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
